shift_xfer_ctrl: RTL and testbench



---
 rtl/shift_xfer_ctrl.sv | 101 ++++++++++
 tb/tb_shift_xfer_ctrl.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/shift_xfer_ctrl.sv
// rtl/shift_xfer_ctrl.sv - full-duplex serial shift transfer controller
// Shifts a parallel word out MSB-first on so while capturing si into the same register.
module shift_xfer_ctrl #(
  parameter  int W   = 4,
  parameter  int DIV = 1,
  localparam int CW  = $clog2(W + 1),
  localparam int DW  = $clog2(DIV + 1)
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [W-1:0] tx_data,
  input  logic         tx_valid,
  output logic         tx_ready,
  input  logic         abort,
  input  logic         si,
  output logic         so,
  output logic         shift_en,
  output logic         busy,
  output logic [W-1:0] rx_data,
  output logic         rx_valid
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  localparam logic [DW-1:0] DIV_LAST = DW'(DIV - 1);
  localparam logic [CW-1:0] BIT_LAST = CW'(W - 1);

  state_t        r_state;
  logic [W-1:0]  r_shreg;
  logic [CW-1:0] r_bit_cnt;
  logic [DW-1:0] r_div_cnt;
  logic [W-1:0]  r_rx_data;
  logic          r_rx_valid;

  logic          w_shift;
  logic [W-1:0]  w_shreg_next;

  assign w_shift      = (r_state == S_SHIFT) && (r_div_cnt == DIV_LAST);
  assign w_shreg_next = {r_shreg[W-2:0], si};

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_shreg    <= '0;
      r_bit_cnt  <= '0;
      r_div_cnt  <= '0;
      r_rx_data  <= '0;
      r_rx_valid <= 1'b0;
    end else begin
      r_rx_valid <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (tx_valid) begin
            r_shreg   <= tx_data;
            r_bit_cnt <= '0;
            r_div_cnt <= '0;
            r_state   <= S_SHIFT;
          end
        end
        S_SHIFT: begin
          // abort wins even over the final shift, so no partial word is ever published
          if (abort) begin
            r_shreg   <= '0;
            r_bit_cnt <= '0;
            r_div_cnt <= '0;
            r_state   <= S_IDLE;
          end else begin
            r_div_cnt <= w_shift ? '0 : r_div_cnt + DW'(1);
            if (w_shift) begin
              r_shreg   <= w_shreg_next;
              r_bit_cnt <= r_bit_cnt + CW'(1);
              if (r_bit_cnt == BIT_LAST) begin
                r_rx_data  <= w_shreg_next;
                r_rx_valid <= 1'b1;
                r_state    <= S_DONE;
              end
            end
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign tx_ready = (r_state == S_IDLE);
  assign busy     = (r_state != S_IDLE);
  assign so       = (r_state == S_SHIFT) ? r_shreg[W-1] : 1'b0;
  assign shift_en = w_shift;
  assign rx_data  = r_rx_data;
  assign rx_valid = r_rx_valid;

endmodule

// File: tb/tb_shift_xfer_ctrl.sv
// tb/tb_shift_xfer_ctrl.sv - self-checking bench for shift_xfer_ctrl
// Instance 0 runs DIV=1, instance 1 runs DIV=3; expectations come from the bit-period timing rules.
module tb_shift_xfer_ctrl;

  localparam int W = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [1:0]        reset;
  logic [1:0]        tx_valid;
  logic [1:0]        abort;
  logic [1:0]        si;
  logic [1:0][W-1:0] tx_data;
  wire  [1:0]        tx_ready;
  wire  [1:0]        so;
  wire  [1:0]        shift_en;
  wire  [1:0]        busy;
  wire  [1:0]        rx_valid;
  wire  [1:0][W-1:0] rx_data;

  int n_checks = 0;
  int n_errors = 0;
  logic [W-1:0] exp_rx [2];

  shift_xfer_ctrl #(.W(W), .DIV(1)) u_d1 (
    .clk(clk), .reset(reset[0]), .tx_data(tx_data[0]), .tx_valid(tx_valid[0]),
    .tx_ready(tx_ready[0]), .abort(abort[0]), .si(si[0]), .so(so[0]),
    .shift_en(shift_en[0]), .busy(busy[0]), .rx_data(rx_data[0]), .rx_valid(rx_valid[0])
  );

  shift_xfer_ctrl #(.W(W), .DIV(3)) u_d3 (
    .clk(clk), .reset(reset[1]), .tx_data(tx_data[1]), .tx_valid(tx_valid[1]),
    .tx_ready(tx_ready[1]), .abort(abort[1]), .si(si[1]), .so(so[1]),
    .shift_en(shift_en[1]), .busy(busy[1]), .rx_data(rx_data[1]), .rx_valid(rx_valid[1])
  );

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%b expected=%b t=%0t", tag, obs, exp, $time);
    end
  endtask

  task automatic chkw(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%b expected=%b t=%0t", tag, obs, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One transfer on instance s. kill: 0 none, 1 abort, 2 reset, asserted during SHIFT cycle kc.
  task automatic xfer(input int s, input int div, input logic [W-1:0] word,
                      input logic [W-1:0] rxw, input int kill, input int kc,
                      input bit keep_valid, input bit abort_hs, input bit noise);
    tx_data[s]  = word;
    tx_valid[s] = 1'b1;
    abort[s]    = abort_hs;
    step();
    abort[s] = 1'b0;
    if (!keep_valid) tx_valid[s] = 1'b0;
    for (int c = 1; c <= W * div; c++) begin
      int j;
      bit se;
      j  = (c - 1) / div;
      se = ((c - 1) % div) == (div - 1);
      chk1("so", so[s], word[W-1-j]);
      chk1("shift_en", shift_en[s], se);
      chk1("busy_shift", busy[s], 1'b1);
      chk1("tx_ready_shift", tx_ready[s], 1'b0);
      chk1("rx_valid_shift", rx_valid[s], 1'b0);
      si[s] = se ? rxw[W-1-j] : 1'($urandom);
      if (noise) begin
        tx_valid[s] = 1'($urandom);
        tx_data[s]  = W'($urandom);
      end
      if (kill != 0 && c == kc) begin
        if (kill == 1) abort[s] = 1'b1;
        else           reset[s] = 1'b1;
        step();
        abort[s]    = 1'b0;
        reset[s]    = 1'b0;
        tx_valid[s] = 1'b0;
        if (kill == 2) exp_rx[s] = '0;
        chk1("busy_kill", busy[s], 1'b0);
        chk1("tx_ready_kill", tx_ready[s], 1'b1);
        chk1("rx_valid_kill", rx_valid[s], 1'b0);
        chk1("so_kill", so[s], 1'b0);
        chkw("rx_data_kill", rx_data[s], exp_rx[s]);
        return;
      end
      step();
    end
    tx_valid[s] = keep_valid;
    exp_rx[s]   = rxw;
    chk1("rx_valid_done", rx_valid[s], 1'b1);
    chkw("rx_data_done", rx_data[s], rxw);
    chk1("busy_done", busy[s], 1'b1);
    chk1("tx_ready_done", tx_ready[s], 1'b0);
    chk1("so_done", so[s], 1'b0);
    chk1("shift_en_done", shift_en[s], 1'b0);
    abort[s] = 1'($urandom);
    step();
    abort[s] = 1'b0;
    chk1("rx_valid_idle", rx_valid[s], 1'b0);
    chk1("tx_ready_idle", tx_ready[s], 1'b1);
    chk1("busy_idle", busy[s], 1'b0);
    chk1("so_idle", so[s], 1'b0);
    chkw("rx_data_hold", rx_data[s], rxw);
  endtask

  initial begin
    reset    = 2'b11;
    tx_valid = 2'b00;
    abort    = 2'b00;
    si       = 2'b00;
    tx_data  = '0;
    exp_rx[0] = '0;
    exp_rx[1] = '0;
    repeat (2) step();
    reset = 2'b00;
    for (int s = 0; s < 2; s++) begin
      chk1("rst_tx_ready", tx_ready[s], 1'b1);
      chk1("rst_busy", busy[s], 1'b0);
      chk1("rst_so", so[s], 1'b0);
      chk1("rst_shift_en", shift_en[s], 1'b0);
      chk1("rst_rx_valid", rx_valid[s], 1'b0);
      chkw("rst_rx_data", rx_data[s], '0);
    end

    xfer(0, 1, 4'b1011, 4'b0110, 0, 0, 1'b0, 1'b0, 1'b0);
    xfer(1, 3, 4'b1100, 4'b1010, 0, 0, 1'b0, 1'b0, 1'b0);

    xfer(0, 1, 4'b1111, 4'b0101, 0, 0, 1'b1, 1'b0, 1'b0);
    xfer(0, 1, 4'b0001, 4'b1101, 0, 0, 1'b0, 1'b0, 1'b0);

    xfer(0, 1, 4'b0101, 4'b1001, 1, 3, 1'b0, 1'b0, 1'b0);
    xfer(0, 1, 4'b1110, 4'b0011, 0, 0, 1'b0, 1'b1, 1'b0);

    xfer(0, 1, 4'b1001, 4'b0111, 2, 4, 1'b0, 1'b0, 1'b1);
    xfer(0, 1, 4'b0110, 4'b1000, 0, 0, 1'b0, 1'b0, 1'b1);
    xfer(1, 3, 4'b0011, 4'b1111, 1, 12, 1'b0, 1'b0, 1'b0);
    xfer(1, 3, 4'b1010, 4'b0100, 2, 12, 1'b0, 1'b0, 1'b1);
    xfer(1, 3, 4'b0111, 4'b1011, 0, 0, 1'b1, 1'b0, 1'b0);
    xfer(1, 3, 4'b1000, 4'b0001, 0, 0, 1'b0, 1'b0, 1'b0);

    for (int n = 0; n < 12; n++) begin
      for (int s = 0; s < 2; s++) begin
        int div;
        int k;
        int kill;
        div  = (s == 0) ? 1 : 3;
        k    = int'($urandom_range(0, 5));
        kill = (k == 0) ? 1 : (k == 1) ? 2 : 0;
        xfer(s, div, W'($urandom), W'($urandom), kill, int'($urandom_range(1, W * div)),
             1'b0, 1'($urandom), 1'b1);
      end
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
